oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 97 +++++++++
 tb/tb_oam_dma.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// Purpose: CPU-triggered 256-byte sprite DMA that copies one CPU page into the PPU OAM data port.
// Latency: bus ownership starts the cycle after the trigger write; 513 or 514 cycles per transfer.
// Backpressure: stalls the CPU through o_cpu_rdy for the whole transfer; nothing stalls the DMA.
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDRESS = 16'h4014,
    parameter logic [15:0] TARGET_ADDRESS  = 16'h2004
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cpu_rw,
    input  logic [15:0] i_cpu_address,
    input  logic [7:0]  i_cpu_data,
    input  logic [7:0]  i_data,
    output logic        o_dma_active,
    output logic        o_cpu_rdy,
    output logic        o_rw,
    output logic [15:0] o_address,
    output logic [7:0]  o_data
);

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    state_t     state;
    logic       parity;    // 0 = get cycle, 1 = put cycle
    logic [7:0] page;
    logic [7:0] counter;
    logic [7:0] byte_reg;

    // Transfer sequencer: HALT, optional ALIGN so reads land on get cycles, then READ/WRITE pairs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            parity   <= 1'b0;
            page     <= 8'h00;
            counter  <= 8'h00;
            byte_reg <= 8'h00;
        end else begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (!i_cpu_rw && (i_cpu_address == TRIGGER_ADDRESS)) begin
                        page    <= i_cpu_data;
                        counter <= 8'h00;
                        state   <= HALT;
                    end
                end
                HALT: begin
                    // A put-cycle halt is already followed by a get cycle; otherwise burn one cycle.
                    state <= parity ? READ : ALIGN;
                end
                ALIGN: begin
                    state <= READ;
                end
                READ: begin
                    byte_reg <= i_data;
                    state    <= WRITE;
                end
                WRITE: begin
                    counter <= counter + 8'd1;
                    state   <= (counter == 8'hFF) ? IDLE : READ;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs decoded purely from registered state; no input reaches an output in the same cycle.
    always_comb begin
        o_dma_active = (state != IDLE);
        o_cpu_rdy    = (state == IDLE);
        o_rw         = 1'b1;
        o_address    = 16'h0000;
        o_data       = 8'h00;
        case (state)
            HALT, ALIGN, READ: begin
                o_address = {page, counter};
                o_data    = byte_reg;
            end
            WRITE: begin
                o_rw      = 1'b0;
                o_address = TARGET_ADDRESS;
                o_data    = byte_reg;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Purpose: self-checking bench for oam_dma; memory model plus read/write scoreboard.
// Latency: each table entry runs one full (or aborted) transfer.
// Backpressure: none; the bench only observes o_cpu_rdy.
module tb_oam_dma;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_cpu_rw;
    logic [15:0] i_cpu_address;
    logic [7:0]  i_cpu_data;
    logic [7:0]  i_data;
    logic        o_dma_active;
    logic        o_cpu_rdy;
    logic        o_rw;
    logic [15:0] o_address;
    logic [7:0]  o_data;

    oam_dma #(
        .TRIGGER_ADDRESS(16'h4014),
        .TARGET_ADDRESS (16'h2004)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_cpu_rw     (i_cpu_rw),
        .i_cpu_address(i_cpu_address),
        .i_cpu_data   (i_cpu_data),
        .i_data       (i_data),
        .o_dma_active (o_dma_active),
        .o_cpu_rdy    (o_cpu_rdy),
        .o_rw         (o_rw),
        .o_address    (o_address),
        .o_data       (o_data)
    );

    always #5 i_clk = ~i_clk;

    // Memory model: every location returns its low address byte XOR a per-test key.
    logic [7:0] mem_key = 8'h00;
    assign i_data = o_address[7:0] ^ mem_key;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];

    // Reference parity: cycles since the last reset edge, LSB.
    int cyc = 0;
    always @(posedge i_clk) begin
        if (!i_reset_n) cyc <= 0;
        else            cyc <= cyc + 1;
    end

    logic        prev_rd     = 1'b0;
    logic [15:0] prev_addr   = 16'h0000;
    logic        prev_par    = 1'b0;
    logic        expect_fall = 1'b0;
    int          active_cycles = 0;
    int          writes_seen   = 0;
    exp_t        mon_e;

    // Bus monitor: pairs each write with the preceding read and pops the scoreboard.
    always @(negedge i_clk) begin
        check("cpu_rdy_inverse", o_cpu_rdy, !o_dma_active);
        if (expect_fall) begin
            check("fall_after_last_write", o_dma_active, 0);
            expect_fall = 1'b0;
        end
        if (!o_dma_active) begin
            check("idle_rw", o_rw, 1);
            check("idle_addr", o_address, 16'h0000);
            check("idle_data", o_data, 8'h00);
        end else begin
            active_cycles++;
            if (!o_rw) begin
                writes_seen++;
                check("wr_addr", o_address, 16'h2004);
                check("wr_after_read", prev_rd, 1);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_write: unexpected write data %0h at %0h, expected no write", o_data, o_address);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rd_addr", prev_addr, mon_e.addr);
                    check("wr_data", o_data, mon_e.data);
                    check("rd_on_get_cycle", prev_par, 0);
                    if (exp_q.size() == 0) expect_fall = 1'b1;
                end
            end
        end
        prev_rd   = o_dma_active && o_rw;
        prev_addr = o_address;
        prev_par  = cyc[0];
    end

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic cpu_idle();
        i_cpu_rw      = 1'b1;
        i_cpu_address = 16'h0000;
        i_cpu_data    = 8'h00;
    endtask

    task automatic cpu_drive(input logic rw, input logic [7:0] data);
        i_cpu_rw      = rw;
        i_cpu_address = 16'h4014;
        i_cpu_data    = data;
        tick();
        cpu_idle();
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 3000 && writes_seen < n; i++) tick();
        check("writes_reached", (writes_seen >= n), 1);
    endtask

    // mode 0: plain transfer, 1: re-trigger at byte 50, 2: trigger during last WRITE, 3: reset at byte 100
    typedef struct {
        logic [7:0] page;
        logic       halt_par;
        logic [7:0] key;
        int         mode;
        int         exp_cycles;
    } vec_t;

    task automatic run_transfer(input vec_t v);
        int ws;
        int ac;
        mem_key = v.key;
        exp_q.delete();
        for (int n = 0; n < 256; n++) begin
            exp_q.push_back('{addr: {v.page, 8'(n)}, data: 8'(n) ^ v.key});
        end
        expect_fall   = 1'b0;
        active_cycles = 0;
        writes_seen   = 0;
        // HALT takes the parity of the cycle after the trigger cycle.
        for (int i = 0; i < 2 && cyc[0] == v.halt_par; i++) tick();
        check("idle_before_trigger", o_dma_active, 0);
        cpu_drive(1'b0, v.page);
        check("dma_rise", o_dma_active, 1);
        check("halt_addr", o_address, {v.page, 8'h00});
        check("halt_rw", o_rw, 1);
        case (v.mode)
            1: begin
                wait_writes(50);
                cpu_drive(1'b0, 8'h09);
            end
            2: begin
                wait_writes(256);
                check("in_last_write", o_rw, 0);
                cpu_drive(1'b0, 8'h33);
            end
            3: begin
                wait_writes(100);
                ws = writes_seen;
                i_reset_n = 1'b0;
                tick();
                i_reset_n = 1'b1;
                check("abort_active", o_dma_active, 0);
                check("abort_addr", o_address, 16'h0000);
                check("abort_rw", o_rw, 1);
                exp_q.delete();
                repeat (20) tick();
                check("no_write_after_reset", writes_seen, ws);
            end
            default: begin
            end
        endcase
        if (v.mode != 3) begin
            for (int i = 0; i < 700 && o_dma_active; i++) tick();
            check("transfer_done", o_dma_active, 0);
            check("active_cycles", active_cycles, v.exp_cycles);
            check("queue_drained", exp_q.size(), 0);
        end
        ac = active_cycles;
        repeat (5) tick();
        check("stays_idle", active_cycles, ac);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{page: 8'h02, halt_par: 1'b1, key: 8'h3C, mode: 0, exp_cycles: 513};
        vecs[1] = '{page: 8'h02, halt_par: 1'b0, key: 8'hC3, mode: 0, exp_cycles: 514};
        vecs[2] = '{page: 8'h07, halt_par: 1'b1, key: 8'h5A, mode: 1, exp_cycles: 513};
        vecs[3] = '{page: 8'hFF, halt_par: 1'b0, key: 8'h5A, mode: 0, exp_cycles: 514};
        vecs[4] = '{page: 8'hFF, halt_par: 1'b1, key: 8'h11, mode: 2, exp_cycles: 513};
        vecs[5] = '{page: 8'h40, halt_par: 1'b0, key: 8'h77, mode: 3, exp_cycles: 0};
        vecs[6] = '{page: 8'h00, halt_par: 1'b0, key: 8'h00, mode: 0, exp_cycles: 514};

        i_reset_n = 1'b0;
        cpu_idle();
        tick();
        tick();
        check("rst_active", o_dma_active, 0);
        check("rst_cpu_rdy", o_cpu_rdy, 1);
        check("rst_rw", o_rw, 1);
        check("rst_addr", o_address, 16'h0000);
        check("rst_data", o_data, 8'h00);
        i_reset_n = 1'b1;
        tick();

        for (int k = 0; k < 7; k++) run_transfer(vecs[k]);

        // A CPU read of the trigger address while idle must not start a transfer.
        active_cycles = 0;
        cpu_drive(1'b1, 8'h55);
        check("read_no_rise", o_dma_active, 0);
        repeat (10) tick();
        check("read_no_trigger", active_cycles, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
